keypad_lock_ctrl: RTL and testbench

//  Parametrised keypad password lock gating the car's drive-command path.

---
 rtl/keypad_lock_if.sv | 26 ++
 rtl/keypad_lock_ctrl.sv | 167 ++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_lock_if.sv
// Keypad lock signal bundle: keypad/drive-command inputs and lock status outputs.
// The controller takes the slave side and the environment takes the master side.
interface keypad_lock_if #(
    parameter int DIGITS = 4,
    parameter int CTRL_W = 3
);
    logic [3:0]          kb_code;
    logic [CTRL_W-1:0]   ctrl_in;
    logic [CTRL_W-1:0]   ctrl_out;
    logic [4*DIGITS-1:0] dig;
    logic                entry_active;
    logic                alarm;
    logic                unlocked;
    logic                locked_out;
    logic [3:0]          fail_cnt;

    modport master (
        output kb_code, ctrl_in,
        input  ctrl_out, dig, entry_active, alarm, unlocked, locked_out, fail_cnt
    );

    modport slave (
        input  kb_code, ctrl_in,
        output ctrl_out, dig, entry_active, alarm, unlocked, locked_out, fail_cnt
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Keypad password lock: gates ctrl_in to ctrl_out while unlocked; alarm, lockout, password change.
// Key events act on the sample tick; all outputs registered, ctrl_out follows ctrl_in with 1 clk latency.
module keypad_lock_ctrl #(
    parameter int                  DIGITS       = 4,
    parameter int                  CTRL_W       = 3,
    parameter int                  SAMPLE_DIV   = 1048576,
    parameter int                  CLK_HZ       = 50000000,
    parameter int                  ALARM_MS     = 2000,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  LOCKOUT_MS   = 10000,
    parameter logic [4*DIGITS-1:0] DEFAULT_PSWD = 16'h2018
) (
    input  logic          clk,
    input  logic          reset,
    keypad_lock_if.slave  bus
);
    localparam int          DW          = 4 * DIGITS;
    localparam int          DIV_W       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int          CNT_W       = $clog2(DIGITS + 1);
    localparam longint      ALARM_CYC   = longint'(CLK_HZ / 1000) * longint'(ALARM_MS);
    localparam longint      LOCKOUT_CYC = longint'(CLK_HZ / 1000) * longint'(LOCKOUT_MS);
    localparam longint      MAX_CYC     = (ALARM_CYC > LOCKOUT_CYC) ? ALARM_CYC : LOCKOUT_CYC;
    localparam int          TW          = $clog2(MAX_CYC + 1);

    localparam logic [3:0]  K_A = 4'hA;
    localparam logic [3:0]  K_B = 4'hB;
    localparam logic [3:0]  K_C = 4'hC;
    localparam logic [3:0]  K_D = 4'hD;
    localparam logic [3:0]  K_F = 4'hF;

    typedef enum logic [2:0] {
        S_LOCKED,
        S_ENTRY,
        S_UNLOCKED,
        S_NEWPW,
        S_LOCKOUT
    } state_t;

    state_t            st, st_eff, st_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        prev_code;
    logic              tick, evt, expire;
    logic [DW-1:0]     dig_r, dig_nxt, pswd, pswd_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        fail, fail_nxt, fail_inc;
    logic              alarm_r, alarm_nxt;
    logic [TW-1:0]     alarm_tmr, alarm_tmr_nxt, lock_tmr, lock_tmr_nxt;

    assign tick   = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign evt    = tick && (bus.kb_code != prev_code) && (bus.kb_code != K_F);
    assign expire = (st == S_LOCKOUT) && (lock_tmr == '0);
    assign fail_inc = (fail < 4'(MAX_FAIL)) ? fail + 4'd1 : fail;

    always_comb begin
        // Lockout expiry is applied before the key is evaluated in the same clk.
        st_eff        = expire ? S_LOCKED : st;
        st_nxt        = st_eff;
        dig_nxt       = dig_r;
        cnt_nxt       = cnt;
        pswd_nxt      = pswd;
        fail_nxt      = expire ? 4'd0 : fail;
        alarm_nxt     = alarm_r;
        alarm_tmr_nxt = alarm_tmr;
        lock_tmr_nxt  = (st == S_LOCKOUT && lock_tmr != '0) ? lock_tmr - TW'(1) : lock_tmr;

        if (expire) begin
            alarm_nxt = 1'b0;
        end else if (st != S_LOCKOUT && alarm_r) begin
            if (alarm_tmr == '0) alarm_nxt = 1'b0;
            else                 alarm_tmr_nxt = alarm_tmr - TW'(1);
        end

        if (evt) begin
            case (st_eff)
                S_LOCKED: begin
                    if (bus.kb_code == K_A) begin
                        st_nxt  = S_ENTRY;
                        dig_nxt = '0;
                        cnt_nxt = '0;
                    end
                end
                S_ENTRY, S_NEWPW: begin
                    if (bus.kb_code <= 4'd9) begin
                        if (cnt < CNT_W'(DIGITS)) begin
                            dig_nxt = (dig_r << 4) | DW'(bus.kb_code);
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else if (bus.kb_code == K_B) begin
                        dig_nxt = '0;
                        cnt_nxt = '0;
                    end else if (bus.kb_code == K_C && cnt == CNT_W'(DIGITS)) begin
                        dig_nxt = '0;
                        cnt_nxt = '0;
                        if (st_eff == S_NEWPW) begin
                            pswd_nxt = dig_r;
                            st_nxt   = S_UNLOCKED;
                        end else if (dig_r == pswd) begin
                            st_nxt    = S_UNLOCKED;
                            fail_nxt  = 4'd0;
                            alarm_nxt = 1'b0;
                        end else begin
                            fail_nxt      = fail_inc;
                            alarm_nxt     = 1'b1;
                            alarm_tmr_nxt = TW'(ALARM_CYC - 1);
                            if (fail_inc == 4'(MAX_FAIL)) begin
                                st_nxt       = S_LOCKOUT;
                                lock_tmr_nxt = TW'(LOCKOUT_CYC - 1);
                            end
                        end
                    end else if (bus.kb_code == K_A && st_eff == S_NEWPW) begin
                        dig_nxt = '0;
                        cnt_nxt = '0;
                        st_nxt  = S_UNLOCKED;
                    end
                end
                S_UNLOCKED: begin
                    if (bus.kb_code == K_A) begin
                        st_nxt = S_LOCKED;
                    end else if (bus.kb_code == K_D) begin
                        st_nxt  = S_NEWPW;
                        dig_nxt = '0;
                        cnt_nxt = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt          <= '0;
            prev_code        <= K_F;
            st               <= S_LOCKED;
            dig_r            <= '0;
            cnt              <= '0;
            pswd             <= DEFAULT_PSWD;
            fail             <= 4'd0;
            alarm_r          <= 1'b0;
            alarm_tmr        <= '0;
            lock_tmr         <= '0;
            bus.ctrl_out     <= '0;
            bus.entry_active <= 1'b0;
            bus.unlocked     <= 1'b0;
            bus.locked_out   <= 1'b0;
        end else begin
            div_cnt          <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) prev_code <= bus.kb_code;
            st               <= st_nxt;
            dig_r            <= dig_nxt;
            cnt              <= cnt_nxt;
            pswd             <= pswd_nxt;
            fail             <= fail_nxt;
            alarm_r          <= alarm_nxt;
            alarm_tmr        <= alarm_tmr_nxt;
            lock_tmr         <= lock_tmr_nxt;
            bus.ctrl_out     <= (st_nxt == S_UNLOCKED) ? bus.ctrl_in : '0;
            bus.entry_active <= (st_nxt == S_ENTRY) || (st_nxt == S_NEWPW);
            bus.unlocked     <= (st_nxt == S_UNLOCKED);
            bus.locked_out   <= (st_nxt == S_LOCKOUT);
        end
    end

    assign bus.dig      = dig_r;
    assign bus.alarm    = alarm_r;
    assign bus.fail_cnt = fail;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with fast timing: 1 ms = 1 clk, key tick every 4 clks.
module tb_keypad_lock_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   fails = 0;
    int   hi_cnt;

    always #5 clk = ~clk;

    keypad_lock_if #(.DIGITS(4), .CTRL_W(3)) bus ();

    keypad_lock_ctrl #(
        .DIGITS(4), .CTRL_W(3), .SAMPLE_DIV(4), .CLK_HZ(1000),
        .ALARM_MS(8), .MAX_FAIL(3), .LOCKOUT_MS(20), .DEFAULT_PSWD(16'h2018)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold a key for one full tick period, then release to F for another.
    task automatic press(input logic [3:0] k);
        bus.kb_code = k;
        repeat (4) @(posedge clk);
        #1 bus.kb_code = 4'hF;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic seq4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, ".unlocked"},   32'(bus.unlocked),     32'd0);
        check({tag, ".entry"},      32'(bus.entry_active), 32'd0);
        check({tag, ".locked_out"}, 32'(bus.locked_out),   32'd0);
        check({tag, ".alarm"},      32'(bus.alarm),        32'd0);
        check({tag, ".fail"},       32'(bus.fail_cnt),     32'd0);
        check({tag, ".dig"},        32'(bus.dig),          32'd0);
        check({tag, ".ctrl_out"},   32'(bus.ctrl_out),     32'd0);
    endtask

    initial begin
        bus.kb_code = 4'hF;
        bus.ctrl_in = 3'b000;
        repeat (3) @(posedge clk);
        check_idle("reset");
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Correct password, overflow digit ignored, then unlock and gate
        press(4'hA);
        @(negedge clk);
        check("entry_after_A", 32'(bus.entry_active), 32'd1);
        seq4(16'h2018);
        press(4'h9);
        @(negedge clk);
        check("dig_full", 32'(bus.dig), 32'h2018);
        press(4'hC);
        @(negedge clk);
        check("unlock", 32'(bus.unlocked), 32'd1);
        check("unlock_dig", 32'(bus.dig), 32'd0);
        check("unlock_entry", 32'(bus.entry_active), 32'd0);
        @(posedge clk);
        #1 bus.ctrl_in = 3'b101;
        @(negedge clk);
        check("ctrl_lat0", 32'(bus.ctrl_out), 32'd0);
        @(negedge clk);
        check("ctrl_lat1", 32'(bus.ctrl_out), 32'b101);
        press(4'hA);
        @(negedge clk);
        check("relock_unl", 32'(bus.unlocked), 32'd0);
        check("relock_ctrl", 32'(bus.ctrl_out), 32'd0);

        // Wrong password: alarm exactly 8 clks, entry keeps going
        press(4'hA);
        seq4(16'h1111);
        bus.kb_code = 4'hC;
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.alarm) hi_cnt++;
            if (i == 4) bus.kb_code = 4'hF;
        end
        check("alarm_len", 32'(hi_cnt), 32'd8);
        check("fail1", 32'(bus.fail_cnt), 32'd1);
        check("fail1_entry", 32'(bus.entry_active), 32'd1);

        // Held key gives one digit; release re-arms; C short is ignored
        bus.kb_code = 4'h5;
        repeat (40) @(posedge clk);
        #1 bus.kb_code = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("hold5", 32'(bus.dig), 32'h0005);
        press(4'h5);
        @(negedge clk);
        check("press55", 32'(bus.dig), 32'h0055);
        press(4'hC);
        @(negedge clk);
        check("short_C_fail", 32'(bus.fail_cnt), 32'd1);
        check("short_C_dig", 32'(bus.dig), 32'h0055);
        press(4'hB);
        @(negedge clk);
        check("clear_B", 32'(bus.dig), 32'd0);

        // Two more failures: lockout with keys ignored, then back to LOCKED
        seq4(16'h1111);
        press(4'hC);
        @(negedge clk);
        check("fail2", 32'(bus.fail_cnt), 32'd2);
        seq4(16'h1111);
        press(4'hC);
        @(negedge clk);
        check("lockout", 32'(bus.locked_out), 32'd1);
        check("lockout_alarm", 32'(bus.alarm), 32'd1);
        check("lockout_fail", 32'(bus.fail_cnt), 32'd3);
        press(4'hA);
        @(negedge clk);
        check("lockout_ignA", 32'(bus.entry_active), 32'd0);
        check("lockout_hold", 32'(bus.locked_out), 32'd1);
        repeat (20) @(posedge clk);
        check_idle("after_lockout");

        // Change password to 4321 and verify old one fails, new one unlocks
        press(4'hA);
        seq4(16'h2018);
        press(4'hC);
        press(4'hD);
        seq4(16'h4321);
        @(negedge clk);
        check("newpw_entry", 32'(bus.entry_active), 32'd1);
        check("newpw_ctrl", 32'(bus.ctrl_out), 32'd0);
        check("newpw_dig", 32'(bus.dig), 32'h4321);
        press(4'hC);
        @(negedge clk);
        check("newpw_unl", 32'(bus.unlocked), 32'd1);
        check("newpw_ctrl_back", 32'(bus.ctrl_out), 32'b101);
        press(4'hA);
        press(4'hA);
        seq4(16'h2018);
        press(4'hC);
        @(negedge clk);
        check("oldpw_rej", 32'(bus.unlocked), 32'd0);
        check("oldpw_fail", 32'(bus.fail_cnt), 32'd1);
        press(4'hA);
        seq4(16'h4321);
        press(4'hC);
        @(negedge clk);
        check("newpw_ok", 32'(bus.unlocked), 32'd1);
        check("newpw_ok_fail", 32'(bus.fail_cnt), 32'd0);
        check("newpw_ok_alarm", 32'(bus.alarm), 32'd0);

        // Reset mid-entry restores default password
        press(4'hA);
        press(4'hA);
        press(4'h2);
        press(4'h0);
        press(4'h1);
        @(negedge clk);
        check("mid_dig", 32'(bus.dig), 32'h0201);
        #2 reset = 1'b0;
        #1;
        check("rst_dig", 32'(bus.dig), 32'd0);
        check("rst_entry", 32'(bus.entry_active), 32'd0);
        check("rst_unl", 32'(bus.unlocked), 32'd0);
        check("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        press(4'hA);
        seq4(16'h2018);
        press(4'hC);
        @(negedge clk);
        check("default_pw", 32'(bus.unlocked), 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
